// File: rtl/mem_wb_multi_pkg.sv
// Shared widths, null constants and stage-action decode for the multi-lane MEM/WB register.
// Optional MEM_WB_PERF_EN feature uses popcount() from here.
package mem_wb_multi_pkg;

  localparam int REG_ADDR_W       = 5;
  localparam int REG_BUS_W        = 32;
  localparam int STALL_W          = 6;
  localparam int MEM_WB_LANES_MAX = 4;

  localparam logic [REG_ADDR_W-1:0] Null_RegAddr = '0;
  localparam logic [REG_BUS_W-1:0]  Zero_Word    = '0;
  localparam logic                  Disabled     = 1'b0;

  typedef enum logic [1:0] {
    ACT_FLUSH,
    ACT_ADVANCE,
    ACT_BUBBLE,
    ACT_HOLD
  } stage_act_e;

  // Flush dominates; an illegal stall pair (this stage free, WB stalled) still advances.
  function automatic stage_act_e decode_act(input logic flush, input logic stall_cur,
                                            input logic stall_next);
    if (flush)           return ACT_FLUSH;
    else if (!stall_cur) return ACT_ADVANCE;
    else if (!stall_next) return ACT_BUBBLE;
    else                 return ACT_HOLD;
  endfunction

  function automatic logic [31:0] popcount(input logic [MEM_WB_LANES_MAX-1:0] v);
    logic [31:0] n;
    n = '0;
    for (int unsigned i = 0; i < MEM_WB_LANES_MAX; i++) n = n + 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/mem_wb_multi_if.sv
// MEM -> WB bus: stall/flush control, per-lane write-back fields and memory-op count loop.
interface mem_wb_multi_if #(
  parameter int LANES  = 2,
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 3
);
  import mem_wb_multi_pkg::*;

  logic [STALL_W-1:0]      stall;
  logic                    flush;
  logic [LANES*REG_AW-1:0] mem_wd;
  logic [LANES-1:0]        mem_wreg;
  logic [LANES*XLEN-1:0]   mem_wdata;
  logic [CNT_W-1:0]        mem_cnt_i;
  logic [CNT_W-1:0]        mem_cnt_o;
  logic [LANES*REG_AW-1:0] wb_wd;
  logic [LANES-1:0]        wb_wreg;
  logic [LANES*XLEN-1:0]   wb_wdata;
  logic                    wb_bubble;

  modport master (
    output stall, flush, mem_wd, mem_wreg, mem_wdata, mem_cnt_i,
    input  mem_cnt_o, wb_wd, wb_wreg, wb_wdata, wb_bubble
  );

  modport slave (
    input  stall, flush, mem_wd, mem_wreg, mem_wdata, mem_cnt_i,
    output mem_cnt_o, wb_wd, wb_wreg, wb_wdata, wb_bubble
  );
endinterface

// File: rtl/mem_wb_multi_lane_filter.sv
// Drops x0 writes and, for lanes sharing a destination, keeps only the highest (youngest) lane.
module mem_wb_lane_filter #(
  parameter int LANES  = 2,
  parameter int REG_AW = 5
) (
  input  logic [LANES*REG_AW-1:0] wd,
  input  logic [LANES-1:0]        wreg,
  output logic [LANES-1:0]        wreg_out
);

  logic [LANES-1:0] live;

  always_comb begin
    live     = '0;
    wreg_out = '0;
    for (int unsigned i = 0; i < LANES; i++)
      live[i] = wreg[i] && (wd[i*REG_AW +: REG_AW] != '0);
    wreg_out = live;
    for (int unsigned i = 0; i < LANES; i++)
      for (int unsigned j = i + 1; j < LANES; j++)
        if (live[j] && (wd[j*REG_AW +: REG_AW] == wd[i*REG_AW +: REG_AW]))
          wreg_out[i] = 1'b0;
  end

endmodule

// File: rtl/mem_wb_multi.sv
// Multi-lane MEM/WB pipeline register with flush, stall-aware bubbles and memory-op count feedback.
// Define MEM_WB_PERF_EN to add retire_cnt/bubble_cnt performance counters.
module mem_wb_multi
  import mem_wb_multi_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 3,
  parameter int STAGE  = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_wb_multi_if.slave bus
`ifdef MEM_WB_PERF_EN
  ,
  output logic [31:0]   retire_cnt,
  output logic [31:0]   bubble_cnt
`endif
);

  logic [LANES*REG_AW-1:0] wd_q;
  logic [LANES-1:0]        wreg_q;
  logic [LANES*XLEN-1:0]   wdata_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    bubble_q;
  logic [LANES-1:0]        wreg_filt;
  stage_act_e              act;
  logic                    stall_unused;

  mem_wb_lane_filter #(.LANES(LANES), .REG_AW(REG_AW)) u_lane_filter (
    .wd       (bus.mem_wd),
    .wreg     (bus.mem_wreg),
    .wreg_out (wreg_filt)
  );

  assign act          = decode_act(bus.flush, bus.stall[STAGE], bus.stall[STAGE+1]);
  assign stall_unused = ^bus.stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q     <= '0;
      wreg_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      bubble_q <= 1'b1;
    end else begin
      unique case (act)
        ACT_FLUSH: begin
          wd_q     <= '0;
          wreg_q   <= '0;
          wdata_q  <= '0;
          cnt_q    <= '0;
          bubble_q <= 1'b1;
        end
        ACT_ADVANCE: begin
          wd_q     <= bus.mem_wd;
          wreg_q   <= wreg_filt;
          wdata_q  <= bus.mem_wdata;
          cnt_q    <= '0;
          bubble_q <= 1'b0;
        end
        ACT_BUBBLE: begin
          wd_q     <= '0;
          wreg_q   <= '0;
          wdata_q  <= '0;
          cnt_q    <= bus.mem_cnt_i;
          bubble_q <= 1'b1;
        end
        default: cnt_q <= bus.mem_cnt_i;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      assert (!(!bus.stall[STAGE] && bus.stall[STAGE+1]))
        else $error("mem_wb_multi: WB stalled while MEM/WB advances");
  end

`ifdef MEM_WB_PERF_EN
  logic [MEM_WB_LANES_MAX-1:0] filt_wide;

  assign filt_wide = MEM_WB_LANES_MAX'(wreg_filt);

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt <= '0;
      bubble_cnt <= '0;
    end else begin
      if (act == ACT_ADVANCE) retire_cnt <= retire_cnt + popcount(filt_wide);
      if (act == ACT_FLUSH || act == ACT_BUBBLE) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

  assign bus.wb_wd     = wd_q;
  assign bus.wb_wreg   = wreg_q;
  assign bus.wb_wdata  = wdata_q;
  assign bus.mem_cnt_o = cnt_q;
  assign bus.wb_bubble = bubble_q;

endmodule

// File: tb/tb_mem_wb_multi.sv
// Directed + random scoreboard bench for mem_wb_multi with LANES=2.
module tb_mem_wb_multi;
  import mem_wb_multi_pkg::*;

  localparam int LANES  = 2;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 3;
  localparam int STAGE  = 4;

  typedef struct {
    string                   tag;
    logic [LANES*REG_AW-1:0] wd;
    logic [LANES-1:0]        wreg;
    logic [LANES*XLEN-1:0]   wdata;
    logic [CNT_W-1:0]        cnt;
    logic                    bubble;
    logic [31:0]             ret;
    logic [31:0]             bub;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  exp_t m;

  always #5 clk = ~clk;

  mem_wb_multi_if #(.LANES(LANES), .XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

`ifdef MEM_WB_PERF_EN
  logic [31:0] retire_cnt, bubble_cnt;
  mem_wb_multi #(.LANES(LANES), .XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W), .STAGE(STAGE)) dut (
    .clk(clk), .rst(rst), .bus(bus), .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt));
`else
  mem_wb_multi #(.LANES(LANES), .XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W), .STAGE(STAGE)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Scan youngest to oldest; the first lane to claim an address keeps it.
  function automatic logic [LANES-1:0] ref_filter(input logic [LANES*REG_AW-1:0] wd,
                                                  input logic [LANES-1:0] wreg);
    logic [31:0]      seen;
    logic [LANES-1:0] r;
    logic [REG_AW-1:0] a;
    seen = '0;
    r    = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      a = wd[i*REG_AW +: REG_AW];
      if (wreg[i] && a != 0) begin
        if (!seen[a]) r[i] = 1'b1;
        seen[a] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_pop(input logic [LANES-1:0] v);
    logic [31:0] n;
    n = 0;
    for (int i = 0; i < LANES; i++) if (v[i]) n++;
    return n;
  endfunction

  task automatic step(input string tag, input logic r, input logic f, input logic [5:0] st,
                      input logic [LANES*REG_AW-1:0] wd, input logic [LANES-1:0] wreg,
                      input logic [LANES*XLEN-1:0] wdata, input logic [CNT_W-1:0] cnt);
    exp_t e;
    rst = r;
    bus.flush = f;
    bus.stall = st;
    bus.mem_wd = wd;
    bus.mem_wreg = wreg;
    bus.mem_wdata = wdata;
    bus.mem_cnt_i = cnt;
    e = m;
    e.tag = tag;
    if (r) begin
      e.wd = '0; e.wreg = '0; e.wdata = '0; e.cnt = '0; e.bubble = 1'b1; e.ret = '0; e.bub = '0;
    end else if (f) begin
      e.wd = '0; e.wreg = '0; e.wdata = '0; e.cnt = '0; e.bubble = 1'b1; e.bub = m.bub + 1;
    end else if (!st[STAGE]) begin
      e.wd = wd; e.wreg = ref_filter(wd, wreg); e.wdata = wdata; e.cnt = '0; e.bubble = 1'b0;
      e.ret = m.ret + ref_pop(e.wreg);
    end else if (!st[STAGE+1]) begin
      e.wd = '0; e.wreg = '0; e.wdata = '0; e.cnt = cnt; e.bubble = 1'b1; e.bub = m.bub + 1;
    end else begin
      e.cnt = cnt;
    end
    m = e;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk({e.tag, ".wd"}, 64'(bus.wb_wd), 64'(e.wd));
    chk({e.tag, ".wreg"}, 64'(bus.wb_wreg), 64'(e.wreg));
    chk({e.tag, ".wdata"}, 64'(bus.wb_wdata), 64'(e.wdata));
    chk({e.tag, ".cnt"}, 64'(bus.mem_cnt_o), 64'(e.cnt));
    chk({e.tag, ".bubble"}, 64'(bus.wb_bubble), 64'(e.bubble));
`ifdef MEM_WB_PERF_EN
    chk({e.tag, ".retire"}, 64'(retire_cnt), 64'(e.ret));
    chk({e.tag, ".bubcnt"}, 64'(bubble_cnt), 64'(e.bub));
`endif
  endtask

  initial begin
    logic [5:0] st;
    logic [LANES*REG_AW-1:0] wd;
    m = '{tag: "init", wd: '0, wreg: '0, wdata: '0, cnt: '0, bubble: 1'b1, ret: '0, bub: '0};

    // Reset with random inputs
    step("rst0", 1'b1, 1'($urandom), 6'($urandom), 10'($urandom), 2'($urandom), {$urandom, $urandom}, 3'($urandom));
    step("rst1", 1'b1, 1'($urandom), 6'($urandom), 10'($urandom), 2'($urandom), {$urandom, $urandom}, 3'($urandom));
    chk("rst_bubble", 64'(bus.wb_bubble), 64'd1);

    step("release", 1'b0, 1'b0, 6'b0, {5'd3, 5'd7}, 2'b11, {32'hAAAA0000, 32'h12345678}, 3'd0);
    chk("release_wdata", 64'(bus.wb_wdata), 64'hAAAA0000_12345678);
    chk("release_wd", 64'(bus.wb_wd), 64'({5'd3, 5'd7}));

    // x0 suppression and same-destination conflict
    step("x0", 1'b0, 1'b0, 6'b0, {5'd9, 5'd0}, 2'b11, {32'h1111, 32'h2222}, 3'd0);
    chk("x0_wreg", 64'(bus.wb_wreg), 64'(2'b10));
    step("conflict", 1'b0, 1'b0, 6'b0, {5'd9, 5'd9}, 2'b11, {32'hB1B1, 32'hA0A0}, 3'd0);
    chk("conflict_wreg", 64'(bus.wb_wreg), 64'(2'b10));
    chk("conflict_win", 64'(bus.wb_wdata[XLEN +: XLEN]), 64'h0000B1B1);

    // Bubble then advance
    step("bubble", 1'b0, 1'b0, 6'b010000, {5'd1, 5'd2}, 2'b11, {32'h5, 32'h6}, 3'd5);
    chk("bubble_cnt", 64'(bus.mem_cnt_o), 64'd5);
    step("post_bubble", 1'b0, 1'b0, 6'b0, {5'd12, 5'd13}, 2'b11, {32'hC, 32'hD}, 3'd6);

    // Hold for three cycles while inputs change
    step("cap4", 1'b0, 1'b0, 6'b0, {5'd6, 5'd4}, 2'b11, {32'hBEEF, 32'hDEAD}, 3'd0);
    for (int unsigned k = 1; k <= 3; k++)
      step("hold", 1'b0, 1'b0, 6'b110000, 10'($urandom), 2'($urandom), {$urandom, $urandom}, 3'(k));
    chk("hold_data", 64'(bus.wb_wdata[0 +: XLEN]), 64'h0000DEAD);
    chk("hold_cnt3", 64'(bus.mem_cnt_o), 64'd3);

    // Flush beats a full stall
    step("flush", 1'b0, 1'b1, 6'b110000, {5'd1, 5'd1}, 2'b11, {32'h1, 32'h2}, 3'd7);
    chk("flush_wreg", 64'(bus.wb_wreg), 64'd0);

    // Ten advances on distinct non-zero destinations
    for (int unsigned k = 0; k < 10; k++)
      step("adv10", 1'b0, 1'b0, 6'b0, {5'(2*k+2), 5'(2*k+1)}, 2'b11, {$urandom, $urandom}, 3'($urandom));

    // Random legal traffic, small address space to provoke conflicts
    for (int unsigned k = 0; k < 60; k++) begin
      st = 6'($urandom) & 6'b001111;
      case ($urandom_range(2))
        0: st[5:4] = 2'b00;
        1: st[5:4] = 2'b01;
        default: st[5:4] = 2'b11;
      endcase
      wd = {5'($urandom_range(3)), 5'($urandom_range(3))};
      step("rand", 1'b0, ($urandom_range(9) == 0), st, wd, 2'($urandom), {$urandom, $urandom},
           3'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
